// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on a shared 64-bit working register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_wb_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    muldiv_state_e     state;
    muldiv_op_e        op;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic              neg_res;
    logic              neg_rem;

    muldiv_op_e        f3;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div0, ovf;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] first_step;
    logic [2*XLEN-1:0] step_mul, step_div, prod_fin;
    logic [XLEN-1:0]   quot_fin, rem_fin;

    // Low half holds the multiplier and shifts out LSB-first; sums enter at the top.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0]   m);
        logic [XLEN:0] s;
        s = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {s, p[XLEN-1:1]};
    endfunction

    // High half is the partial remainder, low half the dividend turning into the quotient.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0]   m);
        logic [XLEN:0] t;
        t = p[2*XLEN-1:XLEN-1] - {1'b0, m};
        return t[XLEN] ? {p[2*XLEN-2:0], 1'b0} : {t[XLEN-1:0], p[XLEN-2:0], 1'b1};
    endfunction

    always_comb begin
        f3       = muldiv_op_e'(i_funct3);
        a_signed = (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
        b_signed = (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
        a_neg    = a_signed & i_rs1_data[XLEN-1];
        b_neg    = b_signed & i_rs2_data[XLEN-1];
        a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
        b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
        div0     = i_funct3[2] && (i_rs2_data == '0);
        ovf      = ((f3 == OP_DIV) || (f3 == OP_REM)) && (i_rs1_data == INT_MIN)
                   && (i_rs2_data == DIV0_QUOT);
        if (div0)
            fast_res = i_funct3[1] ? i_rs1_data : DIV0_QUOT;
        else
            fast_res = i_funct3[1] ? '0 : INT_MIN;
        first_step = i_funct3[2] ? div_step({{XLEN{1'b0}}, a_mag}, b_mag)
                                 : mul_step({{XLEN{1'b0}}, a_mag}, b_mag);

        step_mul = mul_step(prod, mcand);
        step_div = div_step(prod, mcand);
        prod_fin = neg_res ? -step_mul : step_mul;
        quot_fin = neg_res ? -step_div[XLEN-1:0] : step_div[XLEN-1:0];
        rem_fin  = neg_rem ? -step_div[2*XLEN-1:XLEN] : step_div[2*XLEN-1:XLEN];
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op       <= OP_MUL;
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            o_result <= '0;
            o_rd     <= '0;
        end else if (i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    op      <= f3;
                    o_rd    <= i_rd;
                    mcand   <= b_mag;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    // The accept edge already performs the first of the XLEN iterations.
                    prod    <= first_step;
                    cnt     <= CNT_W'(XLEN - 2);
                    if (div0 || ovf) begin
                        o_result <= fast_res;
                        state    <= DONE;
                    end else begin
                        state <= i_funct3[2] ? DIV : MUL;
                    end
                end
                MUL: begin
                    prod <= step_mul;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        o_result <= (op == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
                        state    <= DONE;
                    end
                end
                DIV: begin
                    prod <= step_div;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        o_result <= op[1] ? rem_fin : quot_fin;
                        state    <= DONE;
                    end
                end
                DONE: if (i_wb_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, randomized ops against an
// arithmetic reference, backpressure, flush and asynchronous reset.
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_valid;
    logic        i_wb_ready;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_rd(i_rd), .i_flush(i_flush), .o_valid(o_valid), .i_wb_ready(i_wb_ready),
        .o_result(o_result), .o_rd(o_rd)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return ia / ib;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                  else return ia % ib;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n = 0;
        while (!o_ready && n < 50) begin @(posedge i_clk); #1; n++; end
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL issue_ready: o_ready=%b required 1", o_ready);
        end
        checks++;
        i_valid = 1'b1; i_funct3 = f3; i_rs1_data = a; i_rs2_data = b; i_rd = rd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    // lat = 1 on the first sample after the accept edge
    task automatic wait_valid(output int lat, output bit to);
        lat = 1;
        while (!o_valid && lat < 100) begin @(posedge i_clk); #1; lat++; end
        to = !o_valid;
    endtask

    task automatic retire();
        i_wb_ready = 1'b1;
        @(posedge i_clk); #1;
        i_wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b required 1", o_ready); end
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b required 0", o_valid); end
        checks++;
        if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: %h required 0", o_result); end
        checks++;
        if (o_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: %0d required 0", o_rd); end
        checks++;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [12] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
        logic [31:0] as  [12] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                  32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                                  32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0, 32'd0};
        int          lats[12] = '{32, 32, 32, 32, 32, 32, 32, 1, 1, 1, 1, 32};
        int lat; bit to;
        for (int i = 0; i < 12; i++) begin
            issue(f3s[i], as[i], bs[i], 5'(i + 1));
            wait_valid(lat, to);
            if (to || lat != lats[i]) begin
                errors++; $display("FAIL dir_latency[%0d]: %0d cycles required %0d", i, lat, lats[i]);
            end
            checks++;
            if (o_result !== exp[i]) begin
                errors++; $display("FAIL dir_result[%0d]: %h required %h", i, o_result, exp[i]);
            end
            checks++;
            if (o_rd !== 5'(i + 1)) begin
                errors++; $display("FAIL dir_rd[%0d]: %0d required %0d", i, o_rd, i + 1);
            end
            checks++;
            retire();
        end
    endtask

    task automatic test_random();
        logic [2:0] f3; logic [31:0] a, b; logic [4:0] rd;
        int lat; bit to;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7)); a = pick(); b = pick(); rd = 5'($urandom_range(0, 31));
            issue(f3, a, b, rd);
            wait_valid(lat, to);
            if (to || lat != ref_latency(f3, a, b)) begin
                errors++; $display("FAIL rnd_latency op=%0d a=%h b=%h: %0d required %0d",
                                   f3, a, b, lat, ref_latency(f3, a, b));
            end
            checks++;
            if (o_result !== ref_result(f3, a, b)) begin
                errors++; $display("FAIL rnd_result op=%0d a=%h b=%h: %h required %h",
                                   f3, a, b, o_result, ref_result(f3, a, b));
            end
            checks++;
            if (o_rd !== rd) begin
                errors++; $display("FAIL rnd_rd: %0d required %0d", o_rd, rd);
            end
            checks++;
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        wait_valid(lat, to);
        for (int c = 0; c < 10; c++) begin
            if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hs[%0d]: valid=%b ready=%b required 1/0", c, o_valid, o_ready);
            end
            checks++;
            if (o_result !== 32'hFFFF_FFFE || o_rd !== 5'd17) begin
                errors++; $display("FAIL bp_hold[%0d]: %h/%0d required fffffffe/17", c, o_result, o_rd);
            end
            checks++;
            @(posedge i_clk); #1;
        end
        retire();
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
        checks++;
    endtask

    task automatic test_flush();
        int seen = 0; int lat; bit to;
        // a request coinciding with a flush in IDLE must be dropped
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd9; i_rs2_data = 32'd9;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: ready=%b required 1", o_ready); end
        checks++;
        issue(3'd4, 32'd1000, 32'd7, 5'd5);
        repeat (9) begin @(posedge i_clk); #1; end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_abort: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
        checks++;
        for (int c = 0; c < 40; c++) begin @(posedge i_clk); #1; if (o_valid) seen++; end
        if (seen != 0) begin errors++; $display("FAIL flush_noresult: %0d valid cycles required 0", seen); end
        checks++;
        issue(3'd0, 32'd3, 32'd4, 5'd9);
        wait_valid(lat, to);
        if (to || o_result !== 32'd12 || o_rd !== 5'd9) begin
            errors++; $display("FAIL flush_next: %h/%0d required 0000000c/9", o_result, o_rd);
        end
        checks++;
        retire();
    endtask

    task automatic test_async_reset();
        int lat; bit to;
        issue(3'd0, 32'd123, 32'd456, 5'd21);
        repeat (5) begin @(posedge i_clk); #1; end
        #2 i_rst_n = 1'b0;
        #1;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL areset_hs: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
        checks++;
        if (o_result !== 32'h0 || o_rd !== 5'd0) begin
            errors++; $display("FAIL areset_data: %h/%0d required 0/0", o_result, o_rd);
        end
        checks++;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        issue(3'd0, 32'd6, 32'd7, 5'd3);
        wait_valid(lat, to);
        if (to || lat != 32 || o_result !== 32'd42 || o_rd !== 5'd3) begin
            errors++; $display("FAIL areset_resume: %h/%0d lat %0d required 0000002a/3 lat 32",
                               o_result, o_rd, lat);
        end
        checks++;
        retire();
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_rs1_data = '0; i_rs2_data = '0;
        i_rd = '0; i_flush = 1'b0; i_wb_ready = 1'b0;
        #2;
        test_reset();
        #10 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
